// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage.
package wb_pkg;

  localparam int WB_NUM_CH = 3;

  // Producer channel indices; also the encoding of the rotating pointer.
  typedef enum logic [1:0] {
    WB_CH_IP0 = 2'd0,
    WB_CH_IP1 = 2'd1,
    WB_CH_LSP = 2'd2
  } wb_ch_e;

  // One completed result as offered by a producer.
  typedef struct packed {
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] pc;
    logic        wb_en;
  } wb_xfer_t;

  // Next channel in rotating order (mod 3). Index 3 never occurs but folds to 0.
  function automatic logic [1:0] wb_ch_inc(input logic [1:0] ch);
    return (ch >= 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

endpackage

// File: rtl/wb_rr_arb2of3.sv
// Rotating-priority arbiter granting up to two of three requesters per cycle.
module wb_rr_arb2of3
  import wb_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] rr,
  output logic [2:0] grant,
  output logic [1:0] slot0_ch,
  output logic       slot0_vld,
  output logic [1:0] slot1_ch,
  output logic       slot1_vld,
  output logic [1:0] rr_next
);

  // Walk channels from rr in rotating order, filling slot 0 then slot 1.
  always_comb begin
    logic [1:0] ch;
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    slot0_ch  = '0;
    slot0_vld = 1'b0;
    slot1_ch  = '0;
    slot1_vld = 1'b0;
    rr_next   = rr;
    ch        = (rr > 2'd2) ? 2'd0 : rr;
    for (int i = 0; i < WB_NUM_CH; i++) begin
      if (valid[ch]) begin
        if (!slot0_vld) begin
          slot0_vld = 1'b1;
          slot0_ch  = ch;
          grant[ch] = 1'b1;
        end else if (!slot1_vld) begin
          slot1_vld = 1'b1;
          slot1_ch  = ch;
          grant[ch] = 1'b1;
        end
      end
      ch = wb_ch_inc(ch);
    end
    // Pointer moves past the last channel served; unchanged when nothing is granted.
    if (slot1_vld)      rr_next = wb_ch_inc(slot1_ch);
    else if (slot0_vld) rr_next = wb_ch_inc(slot0_ch);
  end

endmodule

// File: rtl/wb.sv
// Writeback stage: merges ip0/ip1/lsp results onto two register-file write
// ports, releases scoreboard entries and counts retired instructions.
module wb
  import wb_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ip0_wb_dst,
  input  logic [63:0]      ip0_wb_result,
  input  logic [63:0]      ip0_wb_pc,
  input  logic             ip0_wb_wb_en,
  input  logic             ip0_wb_valid,
  output logic             ip0_wb_ready,
  input  logic [4:0]       ip1_wb_dst,
  input  logic [63:0]      ip1_wb_result,
  input  logic [63:0]      ip1_wb_pc,
  input  logic             ip1_wb_wb_en,
  input  logic             ip1_wb_valid,
  output logic             ip1_wb_ready,
  input  logic [4:0]       lsp_wb_dst,
  input  logic [63:0]      lsp_wb_result,
  input  logic [63:0]      lsp_wb_pc,
  input  logic             lsp_wb_wb_en,
  input  logic             lsp_wb_valid,
  output logic             lsp_wb_ready,
  output logic             wb_rf_wen0,
  output logic             wb_rf_wen1,
  output logic [4:0]       wb_rf_wdst0,
  output logic [4:0]       wb_rf_wdst1,
  output logic [63:0]      wb_rf_wdata0,
  output logic [63:0]      wb_rf_wdata1,
  output logic [31:0]      wb_ix_release,
  output logic [63:0]      wb_retire_pc0,
  output logic [63:0]      wb_retire_pc1,
  output logic [1:0]       wb_retire_valid,
  output logic [CNT_W-1:0] wb_instret
);

  logic [1:0] rr;
  logic [1:0] rr_next;
  logic [2:0] valid;
  logic [2:0] grant;
  logic [1:0] slot0_ch, slot1_ch;
  logic       slot0_vld, slot1_vld;
  wb_xfer_t   xfer [4];
  wb_xfer_t   s0, s1;
  logic       s0_wen, s1_wen;
  logic [31:0] release_next;

  assign valid = {lsp_wb_valid, ip1_wb_valid, ip0_wb_valid};

  wb_rr_arb2of3 u_arb (
    .valid     (valid),
    .rr        (rr),
    .grant     (grant),
    .slot0_ch  (slot0_ch),
    .slot0_vld (slot0_vld),
    .slot1_ch  (slot1_ch),
    .slot1_vld (slot1_vld),
    .rr_next   (rr_next)
  );

  // No channel is accepted while reset is held.
  assign ip0_wb_ready = grant[WB_CH_IP0] & ~rst;
  assign ip1_wb_ready = grant[WB_CH_IP1] & ~rst;
  assign lsp_wb_ready = grant[WB_CH_LSP] & ~rst;

  // Gather channel payloads and steer the granted ones into the two slots.
  always_comb begin
    xfer[WB_CH_IP0] = '{dst: ip0_wb_dst, result: ip0_wb_result, pc: ip0_wb_pc, wb_en: ip0_wb_wb_en};
    xfer[WB_CH_IP1] = '{dst: ip1_wb_dst, result: ip1_wb_result, pc: ip1_wb_pc, wb_en: ip1_wb_wb_en};
    xfer[WB_CH_LSP] = '{dst: lsp_wb_dst, result: lsp_wb_result, pc: lsp_wb_pc, wb_en: lsp_wb_wb_en};
    xfer[3]         = '0;
    s0     = slot0_vld ? xfer[slot0_ch] : '0;
    s1     = slot1_vld ? xfer[slot1_ch] : '0;
    // x0 retires but is never written or released.
    s0_wen = s0.wb_en && (s0.dst != 5'd0);
    s1_wen = s1.wb_en && (s1.dst != 5'd0);
    release_next = (s0_wen ? (32'd1 << s0.dst) : 32'd0)
                 | (s1_wen ? (32'd1 << s1.dst) : 32'd0);
  end

  // Register slot results, retire info, pointer and retired-instruction count.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      rr              <= WB_CH_IP0;
      wb_rf_wen0      <= 1'b0;
      wb_rf_wen1      <= 1'b0;
      wb_rf_wdst0     <= '0;
      wb_rf_wdst1     <= '0;
      wb_rf_wdata0    <= '0;
      wb_rf_wdata1    <= '0;
      wb_ix_release   <= '0;
      wb_retire_pc0   <= '0;
      wb_retire_pc1   <= '0;
      wb_retire_valid <= '0;
      wb_instret      <= '0;
    end else begin
      rr              <= rr_next;
      wb_rf_wen0      <= s0_wen;
      wb_rf_wen1      <= s1_wen;
      wb_rf_wdst0     <= s0.dst;
      wb_rf_wdst1     <= s1.dst;
      wb_rf_wdata0    <= s0.result;
      wb_rf_wdata1    <= s1.result;
      wb_ix_release   <= release_next;
      wb_retire_pc0   <= s0.pc;
      wb_retire_pc1   <= s1.pc;
      wb_retire_valid <= {slot1_vld, slot0_vld};
      wb_instret      <= wb_instret + CNT_W'(slot0_vld) + CNT_W'(slot1_vld);
    end
  end

endmodule

// File: tb/tb_wb.sv
// Self-checking bench for wb: random traffic against a behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_wb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Producer-side stimulus, indexed 0=ip0, 1=ip1, 2=lsp.
  logic [4:0]  dst [3];
  logic [63:0] res [3];
  logic [63:0] pc  [3];
  logic        en  [3];
  logic        vld [3];

  wire  [2:0]  rdy;
  wire         wen0, wen1;
  wire  [4:0]  wdst0, wdst1;
  wire  [63:0] wdata0, wdata1;
  wire  [31:0] rel;
  wire  [63:0] rpc0, rpc1;
  wire  [1:0]  rvld;
  wire  [63:0] instret;

  wire  [2:0]  rdy4;
  wire         wen0_4, wen1_4;
  wire  [4:0]  wdst0_4, wdst1_4;
  wire  [63:0] wdata0_4, wdata1_4;
  wire  [31:0] rel_4;
  wire  [63:0] rpc0_4, rpc1_4;
  wire  [1:0]  rvld_4;
  wire  [3:0]  instret4;

  wb #(.CNT_W(64)) u_dut (
    .clk(clk), .rst(rst),
    .ip0_wb_dst(dst[0]), .ip0_wb_result(res[0]), .ip0_wb_pc(pc[0]),
    .ip0_wb_wb_en(en[0]), .ip0_wb_valid(vld[0]), .ip0_wb_ready(rdy[0]),
    .ip1_wb_dst(dst[1]), .ip1_wb_result(res[1]), .ip1_wb_pc(pc[1]),
    .ip1_wb_wb_en(en[1]), .ip1_wb_valid(vld[1]), .ip1_wb_ready(rdy[1]),
    .lsp_wb_dst(dst[2]), .lsp_wb_result(res[2]), .lsp_wb_pc(pc[2]),
    .lsp_wb_wb_en(en[2]), .lsp_wb_valid(vld[2]), .lsp_wb_ready(rdy[2]),
    .wb_rf_wen0(wen0), .wb_rf_wen1(wen1),
    .wb_rf_wdst0(wdst0), .wb_rf_wdst1(wdst1),
    .wb_rf_wdata0(wdata0), .wb_rf_wdata1(wdata1),
    .wb_ix_release(rel),
    .wb_retire_pc0(rpc0), .wb_retire_pc1(rpc1),
    .wb_retire_valid(rvld), .wb_instret(instret)
  );

  // Narrow-counter instance on the same stimulus, for wrap behaviour.
  wb #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .ip0_wb_dst(dst[0]), .ip0_wb_result(res[0]), .ip0_wb_pc(pc[0]),
    .ip0_wb_wb_en(en[0]), .ip0_wb_valid(vld[0]), .ip0_wb_ready(rdy4[0]),
    .ip1_wb_dst(dst[1]), .ip1_wb_result(res[1]), .ip1_wb_pc(pc[1]),
    .ip1_wb_wb_en(en[1]), .ip1_wb_valid(vld[1]), .ip1_wb_ready(rdy4[1]),
    .lsp_wb_dst(dst[2]), .lsp_wb_result(res[2]), .lsp_wb_pc(pc[2]),
    .lsp_wb_wb_en(en[2]), .lsp_wb_valid(vld[2]), .lsp_wb_ready(rdy4[2]),
    .wb_rf_wen0(wen0_4), .wb_rf_wen1(wen1_4),
    .wb_rf_wdst0(wdst0_4), .wb_rf_wdst1(wdst1_4),
    .wb_rf_wdata0(wdata0_4), .wb_rf_wdata1(wdata1_4),
    .wb_ix_release(rel_4),
    .wb_retire_pc0(rpc0_4), .wb_retire_pc1(rpc1_4),
    .wb_retire_valid(rvld_4), .wb_instret(instret4)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int              m_rr;
  longint unsigned m_cnt;
  bit              armed = 1'b0;
  logic            e_wen  [2];
  logic [4:0]      e_dst  [2];
  logic [63:0]     e_data [2];
  logic [63:0]     e_pc   [2];
  logic [1:0]      e_rvld;
  logic [31:0]     e_rel;

  // Checks registered outputs from the last edge, then predicts the next edge
  // from the inputs now offered: serve the first two valid channels starting at m_rr.
  always @(negedge clk) begin : cmp
    int sl [2];
    int ns;
    int c;
    logic [2:0] g;
    if (armed) begin
      check("wen0", wen0, e_wen[0]);
      check("wen1", wen1, e_wen[1]);
      if (e_wen[0]) begin
        check("wdst0", wdst0, e_dst[0]);
        check("wdata0", wdata0, e_data[0]);
      end
      if (e_wen[1]) begin
        check("wdst1", wdst1, e_dst[1]);
        check("wdata1", wdata1, e_data[1]);
      end
      check("release", rel, e_rel);
      check("retire_valid", rvld, e_rvld);
      if (e_rvld[0]) check("retire_pc0", rpc0, e_pc[0]);
      if (e_rvld[1]) check("retire_pc1", rpc1, e_pc[1]);
      check("instret", instret, m_cnt);
      check("instret4", instret4, m_cnt % 16);
    end
    if (rst) begin
      check("ready_in_reset", {rdy4, rdy}, 6'b0);
      m_rr = 0;
      m_cnt = 0;
      for (int s = 0; s < 2; s++) begin
        e_wen[s] = 1'b0; e_dst[s] = '0; e_data[s] = '0; e_pc[s] = '0;
      end
      e_rvld = 2'b00;
      e_rel  = '0;
      armed  = 1'b1;
    end else if (armed) begin
      g = 3'b000;
      ns = 0;
      sl[0] = 0;
      sl[1] = 0;
      for (int k = 0; k < 3; k++) begin
        c = (m_rr + k) % 3;
        if (vld[c] && ns < 2) begin
          sl[ns] = c;
          g[c] = 1'b1;
          ns++;
        end
      end
      check("ready", rdy, g);
      check("ready4", rdy4, g);
      if (ns > 0) m_rr = (sl[ns-1] + 1) % 3;
      m_cnt += longint'(ns);
      e_rvld = (ns == 2) ? 2'b11 : (ns == 1) ? 2'b01 : 2'b00;
      e_rel = '0;
      for (int s = 0; s < 2; s++) begin
        e_wen[s]  = (s < ns) && en[sl[s]] && (dst[sl[s]] != 5'd0);
        e_dst[s]  = dst[sl[s]];
        e_data[s] = res[sl[s]];
        e_pc[s]   = pc[sl[s]];
        if (e_wen[s]) e_rel[dst[sl[s]]] = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0] rdy_q;

  // One clock: sample grants mid-cycle, then land just after the edge.
  task automatic tick();
    @(negedge clk);
    rdy_q = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic new_payload(input int c);
    dst[c] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    res[c] = {$urandom, $urandom};
    pc[c]  = {$urandom, $urandom};
    en[c]  = ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_all_valid(input logic v);
    for (int c = 0; c < 3; c++) vld[c] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_all_valid(1'b0);
    tick();
    rst = 1'b0;
    rdy_q = 3'b000;
  endtask

  // Random producers: a denied offer is held unchanged until granted.
  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (!vld[c] || rdy_q[c]) begin
          new_payload(c);
          vld[c] = ($urandom_range(0, 3) != 0);
        end
      end
      tick();
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [2:0] pat [3];
    int cnt [3];
    int hits;
    int gnt_at;

    for (int c = 0; c < 3; c++) begin
      dst[c] = '0; res[c] = '0; pc[c] = '0; en[c] = 1'b0; vld[c] = 1'b0;
    end
    rdy_q = 3'b000;

    // Reset state.
    do_reset();
    check("rst_wen0", wen0, 0);
    check("rst_wdata0", wdata0, 0);
    check("rst_retire_pc1", rpc1, 0);
    check("rst_instret", instret, 0);

    // Single transfer on ip0.
    dst[0] = 5'd5; res[0] = 64'hDEAD; pc[0] = 64'h400; en[0] = 1'b1; vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    check("t1_ready", rdy_q, 3'b001);
    check("t1_wen0", wen0, 1);
    check("t1_wdst0", wdst0, 5);
    check("t1_wdata0", wdata0, 64'hDEAD);
    check("t1_release", rel, 32'h20);
    check("t1_retire_valid", rvld, 2'b01);
    check("t1_instret", instret, 1);
    tick();
    check("t1_strobe_drop", {wen0, wen1, rel, rvld}, 0);

    // x0 write on ip1 plus a non-writing lsp retire.
    do_reset();
    dst[1] = 5'd0; res[1] = 64'h11; pc[1] = 64'h1000; en[1] = 1'b1; vld[1] = 1'b1;
    dst[2] = 5'd7; res[2] = 64'h22; pc[2] = 64'h2000; en[2] = 1'b0; vld[2] = 1'b1;
    tick();
    set_all_valid(1'b0);
    check("t2_ready", rdy_q, 3'b110);
    check("t2_wen", {wen1, wen0}, 2'b00);
    check("t2_release", rel, 0);
    check("t2_retire_valid", rvld, 2'b11);
    check("t2_retire_pc0", rpc0, 64'h1000);
    check("t2_retire_pc1", rpc1, 64'h2000);
    check("t2_instret", instret, 2);

    // Three-way contention from rr=0.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      dst[c] = 5'(c + 1); res[c] = 64'(c + 100); pc[c] = 64'(c * 4); en[c] = 1'b1; cnt[c] = 0;
    end
    set_all_valid(1'b1);
    pat[0] = 3'b011; pat[1] = 3'b101; pat[2] = 3'b110;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t3_grant_pair", rdy_q, pat[i % 3]);
      for (int c = 0; c < 3; c++) if (rdy_q[c]) cnt[c]++;
    end
    set_all_valid(1'b0);
    check("t3_ip0_count", cnt[0], 4);
    check("t3_ip1_count", cnt[1], 4);
    check("t3_lsp_count", cnt[2], 4);
    check("t3_instret", instret, 12);

    // Stall hold: lsp is denied first and must be written exactly once.
    do_reset();
    dst[0] = 5'd1; res[0] = 64'h1111; en[0] = 1'b1;
    dst[1] = 5'd2; res[1] = 64'h2222; en[1] = 1'b1;
    dst[2] = 5'd9; res[2] = 64'h1234; en[2] = 1'b1; pc[2] = 64'h3000;
    set_all_valid(1'b1);
    hits = 0;
    gnt_at = -1;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (rdy_q[2] && gnt_at < 0) begin
        gnt_at = t;
        vld[2] = 1'b0;
      end
      if (wen0 && wdata0 == 64'h1234) hits++;
      if (wen1 && wdata1 == 64'h1234) hits++;
    end
    set_all_valid(1'b0);
    check("t4_lsp_grant_cycle", 64'(gnt_at), 64'd1);
    check("t4_single_write", hits, 1);

    // Reset in the middle of random traffic.
    do_reset();
    random_traffic(20);
    rst = 1'b1;
    tick();
    check("t5_ready_in_reset", rdy_q, 3'b000);
    check("t5_wen", {wen1, wen0}, 2'b00);
    check("t5_release", rel, 0);
    check("t5_retire_valid", rvld, 2'b00);
    check("t5_instret", instret, 0);
    rst = 1'b0;
    set_all_valid(1'b1);
    tick();
    check("t5_first_grant", rdy_q, 3'b011);
    set_all_valid(1'b0);

    // Counter wrap on the 4-bit instance.
    do_reset();
    set_all_valid(1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 6) check("t6_instret4_pre_wrap", instret4, 14);
    end
    set_all_valid(1'b0);
    check("t6_instret4_wrap", instret4, 0);
    check("t6_instret64", instret, 16);

    // Long random run against the model.
    do_reset();
    random_traffic(600);
    set_all_valid(1'b0);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
